// File: rtl/threshold_track_pkg.sv
// Shared types and helpers for the sequential height/width threshold tracker.
package threshold_track_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DIV, UPDATE} state_e;

  function automatic int prod_w(input int data_w, input int width_w);
    return data_w + width_w;
  endfunction

  // Clamp a signed value into the range of a w-bit two's-complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    else if (x < lo) return lo;
    else return x;
  endfunction

endpackage

// File: rtl/threshold_track_seq_div.sv
// Multi-cycle restoring divider: one quotient bit per clock, MSB first.
module seq_restoring_div #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] numer_i,
  input  logic [W-1:0] denom_i,
  output logic [W-1:0] quotient_o,
  output logic         done_o
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  den_q, den_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    shifted;
  logic [W:0]    diff;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    shifted = {rem_q, quo_q[W-1]};
    diff    = shifted - {1'b0, den_q};
    if (load_i) begin
      rem_d = '0;
      quo_d = numer_i;
      den_d = denom_i;
      cnt_d = CW'(W);
    end else if (cnt_q != '0) begin
      // The remainder stays below den, so diff's top bit is a clean borrow flag.
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rem_q <= '0;
      quo_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      den_q <= den_d;
      cnt_q <= cnt_d;
    end
  end

  // Marks the final iteration; quotient_o holds the full result from the next cycle.
  assign done_o     = (cnt_q == CW'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/threshold_track_seq.sv
// Sequential height/width threshold tracker updated once per pulse peak.
// Optional build macro THRESH_HIGH_FLOOR_EN clamps the new height to HIGH_FLOOR.
module threshold_track_seq
  import threshold_track_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int WIDTH_W    = 8,
  parameter int HIGH_DIV   = 1,
  parameter int WIDTH_DIV  = 2,
  parameter int P_OLD      = 3,
  parameter int P_DIV      = 2,
  parameter int WIDTH_MAX  = 250,
  parameter int WIDTH_SAT  = 200,
  parameter int WIDTH_MIN  = 1,
  parameter int INIT_HIGH  = 400,
  parameter int INIT_WIDTH = 40,
  parameter int HIGH_FLOOR = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic [DATA_W-1:0]  high_max_i,
  output logic [DATA_W-1:0]  th_high_o,
  output logic [WIDTH_W-1:0] th_width_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               skip_o
);

  localparam int PROD_W = prod_w(DATA_W, WIDTH_W);
  localparam int HW     = DATA_W + 4;
  localparam int DW1    = DATA_W + 1;

  localparam logic signed [DATA_W-1:0] INIT_HIGH_S  = DATA_W'(INIT_HIGH);
  localparam logic [WIDTH_W-1:0]       INIT_WIDTH_U = WIDTH_W'(INIT_WIDTH);
  localparam logic signed [HW-1:0]     P_OLD_S      = HW'(P_OLD);

  state_e                     state_q, state_d;
  logic signed [DATA_W-1:0]   hm_q, hm_d;
  logic signed [DATA_W-1:0]   th_high_q, th_high_d;
  logic [WIDTH_W-1:0]         th_width_q, th_width_d;
  logic signed [DATA_W-1:0]   new_high_q, new_high_d;
  logic                       skip_q, skip_d;
  logic                       done_q, done_d;

  logic signed [HW-1:0]       weighted, expect_t, sum_w;
  logic signed [DATA_W-1:0]   new_high_c;
  logic signed [DW1-1:0]      high_old, high_new_raw, high_new;
  logic [PROD_W-1:0]          product, denom;
  logic [PROD_W-1:0]          quotient, q_shift;
  logic [WIDTH_W-1:0]         width_c;
  logic                       div_load, div_done;

  // Height update and the width-ratio operands, all from the captured peak.
  always_comb begin
    weighted   = (P_OLD_S * HW'(th_high_q)) >>> P_DIV;
    expect_t   = HW'(hm_q) >>> (HIGH_DIV + P_DIV);
    sum_w      = weighted + expect_t;
    new_high_c = DATA_W'(sat_signed(64'(sum_w), DATA_W));
`ifdef THRESH_HIGH_FLOOR_EN
    if (new_high_c < DATA_W'(HIGH_FLOOR)) new_high_c = DATA_W'(HIGH_FLOOR);
`endif
    high_old     = DW1'(hm_q) - DW1'(th_high_q);
    high_new_raw = DW1'(hm_q) - DW1'(new_high_c);
    high_new     = high_new_raw[DW1-1] ? '0 : high_new_raw;
    product      = PROD_W'($unsigned(high_new)) * PROD_W'(th_width_q);
    denom        = PROD_W'($unsigned(high_old));
  end

  always_comb begin
    q_shift = quotient >> WIDTH_DIV;
    if (q_shift > PROD_W'(WIDTH_MAX))      width_c = WIDTH_W'(WIDTH_SAT);
    else if (q_shift < PROD_W'(WIDTH_MIN)) width_c = WIDTH_W'(WIDTH_MIN);
    else                                   width_c = q_shift[WIDTH_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    hm_d       = hm_q;
    th_high_d  = th_high_q;
    th_width_d = th_width_q;
    new_high_d = new_high_q;
    skip_d     = skip_q;
    done_d     = 1'b0;
    div_load   = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      th_high_d  = INIT_HIGH_S;
      th_width_d = INIT_WIDTH_U;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            hm_d    = high_max_i;
            state_d = CALC;
          end
        end
        CALC: begin
          new_high_d = new_high_c;
          // A peak at or below the old threshold gives no usable width ratio.
          if (high_old[DW1-1] || (high_old == '0)) begin
            skip_d  = 1'b1;
            state_d = UPDATE;
          end else begin
            skip_d   = 1'b0;
            div_load = 1'b1;
            state_d  = DIV;
          end
        end
        DIV: begin
          if (div_done) state_d = UPDATE;
        end
        UPDATE: begin
          th_high_d = new_high_q;
          if (!skip_q) th_width_d = width_c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      hm_q       <= '0;
      th_high_q  <= INIT_HIGH_S;
      th_width_q <= INIT_WIDTH_U;
      new_high_q <= '0;
      skip_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hm_q       <= hm_d;
      th_high_q  <= th_high_d;
      th_width_q <= th_width_d;
      new_high_q <= new_high_d;
      skip_q     <= skip_d;
      done_q     <= done_d;
    end
  end

  seq_restoring_div #(
    .W (PROD_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (div_load),
    .numer_i    (product),
    .denom_i    (denom),
    .quotient_o (quotient),
    .done_o     (div_done)
  );

  assign th_high_o  = th_high_q;
  assign th_width_o = th_width_q;
  assign done_o     = done_q;
  assign skip_o     = done_q & skip_q;
  // Busy covers the done cycle so it drops one clock after the pulse.
  assign busy_o     = (state_q != IDLE) | done_q;

endmodule

// File: tb/tb_threshold_track_seq.sv
// Directed self-checking bench for threshold_track_seq at default parameters.
module tb_threshold_track_seq;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               clear;
  logic signed [15:0] high_max;
  logic [15:0]        th_high;
  logic [7:0]         th_width;
  logic               busy;
  logic               done;
  logic               skip;

  int total = 0;
  int bad   = 0;

  threshold_track_seq dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .clear_i    (clear),
    .high_max_i (high_max),
    .th_high_o  (th_high),
    .th_width_o (th_width),
    .busy_o     (busy),
    .done_o     (done),
    .skip_o     (skip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int exp_h, input int exp_w);
    chk({tag, "_high"}, $signed(th_high), exp_h);
    chk({tag, "_width"}, {24'd0, th_width}, exp_w);
  endtask

  task automatic do_clear(input string tag);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_outputs(tag, 400, 40);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  // Latency counts rising edges after the edge that sampled start.
  task automatic run_op(input string tag, input int hm, input int exp_lat,
                        input int exp_h, input int exp_w, input int exp_skip);
    int lat;
    @(negedge clk);
    start    = 1'b1;
    high_max = 16'(hm);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk_outputs(tag, exp_h, exp_w);
    chk({tag, "_skip"}, {31'd0, skip}, exp_skip);
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 0);
    chk({tag, "_busy_low"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int ndone;
    rst_n    = 1'b0;
    start    = 1'b0;
    clear    = 1'b0;
    high_max = '0;
    repeat (3) @(negedge clk);
    chk_outputs("reset", 400, 40);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_skip", {31'd0, skip}, 0);
    rst_n = 1'b1;

    run_op("basic", 1000, 26, 425, 9, 0);
    do_clear("clr1");
    run_op("sat_hi", 401, 26, 350, 200, 0);
    run_op("chain", 1000, 26, 387, 47, 0);
    do_clear("clr2");
    run_op("skip_pos", 300, 2, 337, 40, 1);
    do_clear("clr3");
    run_op("skip_neg", -800, 2, 200, 40, 1);
    do_clear("clr4");
    run_op("big1", 32767, 26, 4395, 8, 0);
    run_op("big2", 32767, 26, 7391, 1, 0);
    run_op("min_clamp", 32767, 26, 9638, 1, 0);
    do_clear("clr5");

    // Second start while busy and a changed peak after accept must not matter.
    @(negedge clk);
    start    = 1'b1;
    high_max = 16'sd1000;
    @(negedge clk);
    start    = 1'b0;
    high_max = 16'sd5;
    ndone    = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) start = 1'b1;
      if (i == 4) start = 1'b0;
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("ignore_done_count", ndone, 1);
    chk_outputs("ignore", 425, 9);

    // Clear in the middle of the division aborts with no done pulse.
    @(negedge clk);
    start    = 1'b1;
    high_max = 16'sd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_busy_before", {31'd0, busy}, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_outputs("abort", 400, 40);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    // Asynchronous reset during the division.
    run_op("pre_rst", 1000, 26, 425, 9, 0);
    @(negedge clk);
    start    = 1'b1;
    high_max = 16'sd2000;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs("arst", 400, 40);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_skip", {31'd0, skip}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 1000, 26, 425, 9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/threshold_track_seq.md
Name: threshold_track_seq

Overview:
Sequential, parametrised successor to the combinational threshold tracker in the Rx_Channel Wave_Deal path. Owns the height and width thresholds as internal state, with reset and clear reloading them to init values. Each start_i updates them from a new pulse peak (high_max_i).
- Height: new_high = P_OLD*old_high/2^P_DIV + high_max/2^(HIGH_DIV+P_DIV)
- Width: new_width = old_width*(high_max-new_high)/(high_max-old_high)/2^WIDTH_DIV, saturated
- Single multi-cycle restoring divider replaces the wide combinational divide; start/done handshake.

Parameters:
- DATA_W, 16, signed height/peak width
- WIDTH_W, 8, unsigned width-threshold width
- HIGH_DIV, 1, height fraction shift
- WIDTH_DIV, 2, width fraction shift
- P_OLD, 3, old-threshold weight numerator
- P_DIV, 2, weight denominator shift
- WIDTH_MAX, 250, quotient limit before saturation
- WIDTH_SAT, 200, width value used when quotient > WIDTH_MAX
- WIDTH_MIN, 1, lower clamp on width result
- INIT_HIGH, 400, height threshold after reset/clear
- INIT_WIDTH, 40, width threshold after reset/clear
- HIGH_FLOOR, 64, minimum height (optional feature only)

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  request update; sampled only in IDLE
- clear_i  in  1  synchronous abort and reload of init thresholds
- high_max_i  in  DATA_W  signed pulse peak; captured when start accepted
- th_high_o  out  DATA_W  signed current height threshold
- th_width_o  out  WIDTH_W  current width threshold
- busy_o  out  1  high from accept until done
- done_o  out  1  one-cycle pulse when thresholds updated
- skip_o  out  1  valid with done_o; division skipped

Behaviour:
Reset values: th_high_o=INIT_HIGH, th_width_o=INIT_WIDTH, busy_o=0, done_o=0, skip_o=0, FSM=IDLE.

Arithmetic:
- Let PROD_W = DATA_W+WIDTH_W.
- Weighted term: signed P_OLD*old_high in DATA_W+4 bits, then >>> P_DIV.
- Expect term: high_max >>> (HIGH_DIV+P_DIV).
- new_high = sum of the two terms, saturated to the signed DATA_W range.
- high_old = high_max-old_high; high_new = high_max-new_high; both DATA_W+1 signed.
- If high_new < 0 it is treated as 0.

FSM:
- IDLE: start_i & !clear_i → capture high_max_i, go to CALC, busy_o=1.
- CALC (1 cycle): compute new_high, high_old, high_new and product = high_new*old_width (PROD_W unsigned).
  - If high_old <= 0: go to UPDATE with skip flag set; width kept.
  - Otherwise load the divider and go to DIV.
- DIV: PROD_W cycles, one quotient bit per cycle, MSB first; then UPDATE.
- UPDATE (1 cycle): q = quotient >> WIDTH_DIV.
  - width = WIDTH_SAT if q > WIDTH_MAX; WIDTH_MIN if q < WIDTH_MIN; else q.
  - Register both thresholds; done_o=1; skip_o=flag; busy_o falls next cycle; return to IDLE.

Latency: done_o is high in the cycle PROD_W+2 clocks after the start-sampling edge (26 cycles at defaults), or 2 clocks on the skip path. Threshold outputs change on the same edge that raises done_o.

Boundaries:
- start_i while busy: ignored, no queueing.
- clear_i in any state: next edge goes to IDLE, reloads INIT values, done_o=0, no done pulse for an aborted op.
- start_i and clear_i together: clear wins.
- Asynchronous reset mid-operation: immediate return to reset values.
- high_max_i changing after accept: no effect.

Optional Feature:
THRESH_HIGH_FLOOR_EN
- Defined: new_high is clamped to >= HIGH_FLOOR before high_new is computed and before registering.
- Undefined: no floor; HIGH_FLOOR is unused.

Decomposition:
- Package threshold_track_pkg holds:
  - state enum {IDLE, CALC, DIV, UPDATE}
  - PROD_W derivation function
  - saturate-to-signed-width function
- One sub-module: seq_restoring_div, parametrised by width.
  - Ports: clk_i, rst_n_i, load_i, numer_i, denom_i, quotient_o, done_o.
  - Denominator is guaranteed > 0 by the parent.

Test Plan:
- After reset, high_max 1000 → after 26 cycles: th_high_o=425, th_width_o=9 (23000/600=38, >>2), skip_o=0.
- Init thresholds (400, 40), set state to high 990 / width 255, then high_max 1000 → 33915/10=3391, >>2=847 > 250 → th_width_o=200, th_high_o=867.
- From init (400, 40), high_max 300 → done after 2 cycles: skip_o=1, th_high_o=337, th_width_o=40.
- From init (400, 40), high_max -800 → skip_o=1, th_high_o=200, width unchanged.
- start_i pulsed at cycle 5 of a busy op → ignored, exactly one done. clear_i at cycle 10 of DIV → no done_o, outputs 400/40, busy_o=0 next cycle.
- Assert rst_n_i low mid-DIV → outputs return to reset values immediately. With THRESH_HIGH_FLOOR_EN, high_max -800 → th_high_o=200 (above floor); repeated negative peaks converge to 64, never below.
